// File: rtl/conv_sequencer.sv
// conv_sequencer: walks the (n, k) index space of a linear convolution, issuing x/h read
// addresses and MAC strobes delayed by PIPE cycles, with a start/busy/done handshake.
module conv_sequencer #(
    parameter int AW   = 3,
    parameter int PIPE = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW:0]   lx,
    input  logic [AW:0]   lh,
    input  logic          stall,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] h_addr,
    output logic          rd_en,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          y_last,
    output logic [AW+1:0] y_idx,
    output logic          busy,
    output logic          done
);
    localparam int DW = AW + 5;
    localparam logic [AW+1:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state;

    logic [AW:0]   lx_q, lh_q;
    logic [AW+1:0] lx_w, lh_w, n, k, n1, nn, kn, kmin, kmax, kmin1, n_end;
    logic [AW-1:0] hn;
    logic          run, clr_i, last_i, fin_i, pend;
    logic [DW-1:0] issue, tail;

    assign lx_w   = {1'b0, lx_q};
    assign lh_w   = {1'b0, lh_q};
    assign n1     = n + ONE;
    assign kmin   = (n >= lh_w) ? n - lh_w + ONE : '0;
    assign kmax   = (n < lx_w) ? n : lx_w - ONE;
    assign kmin1  = (n1 >= lh_w) ? n1 - lh_w + ONE : '0;
    assign n_end  = lx_w + lh_w - ONE - ONE;
    assign clr_i  = k == kmin;
    assign last_i = k == kmax;
    assign fin_i  = last_i && n == n_end;
    assign nn     = last_i ? n1 : n;
    assign kn     = last_i ? kmin1 : k + ONE;
    assign hn     = AW'(nn - kn);
    assign run    = state == RUN;
    assign issue  = {run, run && clr_i, run && last_i, run ? n : '0};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= IDLE;
            lx_q   <= '0;
            lh_q   <= '0;
            n      <= '0;
            k      <= '0;
            x_addr <= '0;
            h_addr <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    lx_q   <= lx;
                    lh_q   <= lh;
                    n      <= '0;
                    k      <= '0;
                    x_addr <= '0;
                    h_addr <= '0;
                    state  <= (lx == '0 || lh == '0) ? FIN : RUN;
                end
                RUN: if (!stall) begin
                    if (fin_i) state <= (PIPE == 0) ? FIN : DRAIN;
                    else begin
                        n      <= nn;
                        k      <= kn;
                        x_addr <= kn[AW-1:0];
                        h_addr <= hn;
                    end
                end
                DRAIN: if (!stall && !pend) state <= FIN;
                default: state <= IDLE;
            endcase
        end
    end

    // Each stage carries {en, clr, last, y_idx}; the stage about to leave is ignored when draining.
    generate
        if (PIPE == 0) begin : g_nopipe
            assign tail = issue;
            assign pend = 1'b0;
        end else begin : g_pipe
            logic [DW-1:0] line [PIPE];
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    for (int i = 0; i < PIPE; i++) line[i] <= '0;
                end else if (!stall) begin
                    line[0] <= issue;
                    for (int i = 1; i < PIPE; i++) line[i] <= line[i-1];
                end
            end
            always_comb begin
                pend = 1'b0;
                for (int i = 0; i < PIPE - 1; i++) pend = pend | line[i][DW-1];
            end
            assign tail = line[PIPE-1];
        end
    endgenerate

    assign rd_en   = run && !stall;
    assign mac_en  = tail[DW-1] && !stall;
    assign mac_clr = tail[DW-2] && !stall;
    assign y_last  = tail[DW-3] && !stall;
    assign y_idx   = tail[AW+1:0];
    assign busy    = state == RUN || state == DRAIN;
    assign done    = state == FIN;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: scoreboard bench driving three sequencers (PIPE 0, 2, 7) in lockstep
// and checking the selected one against an independently enumerated term list.
module tb_conv_sequencer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic [3:0] lx = '0, lh = '0;

    logic [2:0] xa0, ha0, xa2, ha2, xa7, ha7, xa, ha;
    logic [4:0] yi0, yi2, yi7, yi;
    logic rd0, mc0, me0, yl0, bz0, dn0;
    logic rd2, mc2, me2, yl2, bz2, dn2;
    logic rd7, mc7, me7, yl7, bz7, dn7;
    logic rd, mc, me, yl, bz, dn;
    int sel = 2;
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [2:0] x, h;
        logic clr, last;
        logic [4:0] idx;
    } term_t;
    term_t iq[$], mq[$];

    always #5 clk = ~clk;

    conv_sequencer #(.AW(3), .PIPE(0)) d0 (.clk(clk), .rstn(rstn), .start(start), .lx(lx), .lh(lh), .stall(stall),
        .x_addr(xa0), .h_addr(ha0), .rd_en(rd0), .mac_clr(mc0), .mac_en(me0), .y_last(yl0), .y_idx(yi0), .busy(bz0), .done(dn0));
    conv_sequencer #(.AW(3), .PIPE(2)) d2 (.clk(clk), .rstn(rstn), .start(start), .lx(lx), .lh(lh), .stall(stall),
        .x_addr(xa2), .h_addr(ha2), .rd_en(rd2), .mac_clr(mc2), .mac_en(me2), .y_last(yl2), .y_idx(yi2), .busy(bz2), .done(dn2));
    conv_sequencer #(.AW(3), .PIPE(7)) d7 (.clk(clk), .rstn(rstn), .start(start), .lx(lx), .lh(lh), .stall(stall),
        .x_addr(xa7), .h_addr(ha7), .rd_en(rd7), .mac_clr(mc7), .mac_en(me7), .y_last(yl7), .y_idx(yi7), .busy(bz7), .done(dn7));

    always_comb begin
        xa = sel == 0 ? xa0 : sel == 7 ? xa7 : xa2;
        ha = sel == 0 ? ha0 : sel == 7 ? ha7 : ha2;
        yi = sel == 0 ? yi0 : sel == 7 ? yi7 : yi2;
        rd = sel == 0 ? rd0 : sel == 7 ? rd7 : rd2;
        mc = sel == 0 ? mc0 : sel == 7 ? mc7 : mc2;
        me = sel == 0 ? me0 : sel == 7 ? me7 : me2;
        yl = sel == 0 ? yl0 : sel == 7 ? yl7 : yl2;
        bz = sel == 0 ? bz0 : sel == 7 ? bz7 : bz2;
        dn = sel == 0 ? dn0 : sel == 7 ? dn7 : dn2;
    end

    task automatic check_zero(input string tag);
        checks++;
        if ({xa, ha, rd, mc, me, yl, yi, bz, dn} !== '0)
            begin errors++; $display("FAIL %s outputs: got %h required 0", tag, {xa, ha, rd, mc, me, yl, yi, bz, dn}); end
    endtask

    // Expected terms enumerated by scanning every (n, k) pair and keeping in-range h indices.
    task automatic load_model(input int a, input int b);
        term_t t;
        iq.delete();
        mq.delete();
        for (int n = 0; n <= a + b - 2; n++) begin
            bit first = 1'b1;
            for (int k = 0; k < a; k++) begin
                if (n - k >= 0 && n - k < b) begin
                    t.x = 3'(k);
                    t.h = 3'(n - k);
                    t.clr = first;
                    t.last = !(k + 1 < a && n - k - 1 >= 0);
                    t.idx = 5'(n);
                    first = 1'b0;
                    iq.push_back(t);
                    mq.push_back(t);
                end
            end
        end
    endtask

    task automatic run(input int a, input int b, input int s, input int st_at, input int st_len,
                       input int exp_done, input int rst_at, input int ign_at);
        int cyc = 0;
        bit seen = 1'b0;
        term_t e;
        sel = s;
        load_model(a, b);
        @(posedge clk); #1;
        start = 1'b1; lx = 4'(a); lh = 4'(b);
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen && cyc < exp_done + 20) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            cyc++;
            stall = cyc >= st_at && cyc < st_at + st_len;
            start = cyc == ign_at;
            if (cyc == ign_at) begin lx = 4'd5; lh = 4'd5; end
            @(negedge clk);
            if (rd) begin
                checks++;
                if (iq.size() == 0) begin errors++; $display("FAIL extra_issue cyc=%0d got x=%0d h=%0d required none", cyc, xa, ha); end
                else begin
                    e = iq.pop_front();
                    if ({xa, ha} !== {e.x, e.h})
                        begin errors++; $display("FAIL issue cyc=%0d got x=%0d h=%0d required x=%0d h=%0d", cyc, xa, ha, e.x, e.h); end
                end
            end
            if (me) begin
                checks++;
                if (mq.size() == 0) begin errors++; $display("FAIL extra_mac cyc=%0d got idx=%0d required none", cyc, yi); end
                else begin
                    e = mq.pop_front();
                    if ({mc, yl, yi} !== {e.clr, e.last, e.idx})
                        begin errors++; $display("FAIL mac cyc=%0d got clr=%b last=%b idx=%0d required clr=%b last=%b idx=%0d",
                                                 cyc, mc, yl, yi, e.clr, e.last, e.idx); end
                end
            end
            checks++;
            if (bz !== (cyc < exp_done && a != 0 && b != 0))
                begin errors++; $display("FAIL busy cyc=%0d got %b required %b", cyc, bz, cyc < exp_done && a != 0 && b != 0); end
            checks++;
            if (dn !== (cyc == exp_done)) begin errors++; $display("FAIL done cyc=%0d got %b required %b", cyc, dn, cyc == exp_done); end
            seen = dn;
            if (rst_at != 0 && cyc == rst_at) begin
                rstn = 1'b0;
                @(posedge clk); #1;
                rstn = 1'b1;
                @(negedge clk);
                check_zero("mid_reset");
                stall = 1'b0;
                start = 1'b0;
                return;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL timeout got no done required done at cycle %0d", exp_done); end
        checks++;
        if (iq.size() != 0 || mq.size() != 0)
            begin errors++; $display("FAIL leftover got issue=%0d mac=%0d required 0 0", iq.size(), mq.size()); end
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        sel = 2; check_zero("reset_p2");
        sel = 0; check_zero("reset_p0");
        sel = 7; check_zero("reset_p7");
    endtask

    task automatic test_basic();        run(3, 3, 2, 0, 0, 12, 0, 0); endtask
    task automatic test_single_h();     run(8, 1, 0, 0, 0, 9, 0, 0); endtask
    task automatic test_zero_length();  run(0, 5, 2, 0, 0, 1, 0, 0); run(4, 0, 7, 0, 0, 1, 0, 0); endtask
    task automatic test_stall();        run(3, 3, 2, 5, 3, 15, 0, 0); endtask
    task automatic test_mid_reset();    run(3, 3, 2, 0, 0, 12, 4, 2); run(3, 3, 2, 0, 0, 12, 0, 0); endtask
    task automatic test_max();          run(8, 8, 7, 0, 0, 72, 0, 0); endtask
    task automatic test_back_to_back(); run(2, 5, 2, 0, 0, 13, 0, 0); run(5, 2, 0, 4, 2, 13, 0, 0); endtask

    initial begin
        test_reset();
        test_basic();
        test_single_h();
        test_zero_length();
        test_stall();
        test_mid_reset();
        test_max();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Control sequencer for the linear-convolution datapath: y[n] = sum over k of x[k]·h[n−k], for n = 0..LX+LH−2. It walks the (n, k) index space with nested counters and drives the read addresses for the x and h sample memories. It also generates MAC clear/accumulate/output strobes, delayed to match the datapath pipeline depth, and reports completion with a start/busy/done handshake. It sits between the top-level control (start, lengths) and the memory + MAC datapath.

## Interface
- AW, 3, address width of x and h memories; max length 2^AW each
- PIPE, 2, datapath latency in cycles from address issue to MAC input (0..7)
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, synchronous, active-low
- start  input  1  begin a convolution; sampled only in IDLE
- lx  input  AW+1  x length, 0..2^AW, sampled with start
- lh  input  AW+1  h length, 0..2^AW, sampled with start
- stall  input  1  freeze issue counters and delay pipeline while high
- x_addr  output  AW  x memory read address (k)
- h_addr  output  AW  h memory read address (n−k)
- rd_en  output  1  addresses valid this cycle
- mac_clr  output  1  delayed by PIPE; first term of current y[n], load instead of accumulate
- mac_en  output  1  delayed by PIPE; term valid at MAC input
- y_last  output  1  delayed by PIPE; last term of current y[n], result complete after this term
- y_idx  output  AW+2  delayed by PIPE; n of the term at the MAC
- busy  output  1  high from first issue cycle until last delayed term has left
- done  output  1  one-cycle pulse on completion

## Operation
- States: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 latches lx and lh.
  - If either length is 0, go to FIN; no rd_en or mac_en is ever asserted.
  - Otherwise go to RUN with n=0, k=0.
- RUN: one term is issued per non-stalled cycle, in order n ascending, then k ascending from kmin=max(0, n−LH+1) to kmax=min(n, LX−1).
  - Each issued term drives x_addr=k, h_addr=n−k, rd_en=1.
  - First term of each n carries clr=1. Last term (k==kmax) carries last=1.
  - A single-term n carries both clr and last.
  - After the term with n=LX+LH−2 and k=kmax is issued, go to DRAIN.
- DRAIN: wait until the PIPE-deep delay line holds no valid term, then go to FIN. With PIPE=0, go directly to FIN.
- FIN: done=1 for one cycle, then return to IDLE.
- Delay line: a PIPE-stage shift register carries {en, clr, last, y_idx}. Outputs are taken from its last stage; with PIPE=0 the outputs equal the issue-stage values.
- Arithmetic:
  - n counter is AW+2 bits.
  - kmin and kmax are computed in AW+2 bits with no wrap.
  - h_addr = (n−k) truncated to AW bits; it is always in range by construction.
- stall=1: counters, state and delay line all hold. rd_en is forced to 0, and mac_en/mac_clr/y_last are forced to 0 for that cycle. Addresses keep their values.
- start while not IDLE is ignored. lx and lh changes after sampling are ignored.
- Reset, including mid-operation:
  - State goes to IDLE and all counters and the delay line are cleared.
  - All outputs are 0: addresses, rd_en, mac_*, y_last, y_idx, busy, done.

## Timing
- Edge E0 samples start=1. The first issue appears in the cycle after E0, with rd_en=1 and busy=1.
- The issue phase lasts exactly LX·LH non-stalled cycles.
- Delayed strobes lag rd_en by exactly PIPE non-stalled cycles.
- busy falls in the same cycle done pulses. done comes PIPE+1 non-stalled cycles after the last issue cycle.
- Without stalls, a run takes LX·LH+PIPE+1 cycles from the cycle after E0 to done, inclusive.
- The zero-length case: done pulses in the cycle after E0; busy stays 0.
- A new start is accepted in the cycle done is high? No: it is accepted on the first IDLE cycle after FIN.

## Test plan
- LX=LH=3, PIPE=2, no stall:
  - (x_addr, h_addr) sequence is (0,0) (0,1)(1,0) (0,2)(1,1)(2,0) (1,2)(2,1) (2,2).
  - 9 rd_en cycles; mac_clr on terms 1,2,4,7,9 and y_last on terms 1,3,6,8,9.
  - y_idx runs 0..4 on the delayed strobes.
  - done in cycle 12 after E0.
- LX=8, LH=1, PIPE=0: 8 terms, each with clr=last=1, y_idx 0..7, h_addr always 0, done in cycle 9.
- lx=0, lh=5: done pulses in cycle 1; rd_en, mac_en and busy stay 0 throughout.
- LX=LH=3, PIPE=2, stall held for 3 cycles during term 5:
  - Sequence and strobe pattern are identical to the no-stall case, with no term lost or duplicated.
  - done is delayed to cycle 15.
- rstn=0 mid-RUN at term 4, with start asserted during RUN:
  - All outputs are 0 in the cycle after the reset edge.
  - The ignored start has no effect.
  - A new start after reset reproduces the full LX=LH=3 sequence from (0,0).
- LX=LH=8 (AW=3 max), PIPE=7: 64 issues, max y_idx=14, kmin/kmax correct at n=7 and n=14, done at cycle 72.
